ov5640_init_seq: RTL
====================

OV5640_INIT_SEQ -- requirements
Module: ov5640_init_seq

Interface
REQ-001 Parameter TABLE_SIZE, default 250, number of valid init-table entries (indices 0..TABLE_SIZE-1).
REQ-002 Parameter ADDR_WIDTH, default 8, width of the table address.
REQ-003 Parameter PWRUP_CYCLES, default 1_000_000, idle wait after start before the first write (20 ms at 50 MHz).
REQ-004 Parameter RST_IDX, default 1, table index whose write is followed by a post-write delay (software reset entry).
REQ-005 Parameter RST_DLY_CYCLES, default 250_000, post-write delay after entry RST_IDX (5 ms at 50 MHz).
REQ-006 Parameter MAX_RETRY, default 3, write retries per entry after an error, before abort.
REQ-007 clk  in  1  single system clock; all logic is on its rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 start  in  1  one-cycle pulse that begins a sequence; ignored unless idle, done or failed.
REQ-010 rom_addr  out  ADDR_WIDTH  init-table read address.
REQ-011 rom_q  in  24  init-table data {reg_addr[15:0], reg_data[7:0]}, valid one clk after rom_addr.
REQ-012 wr_req  out  1  register-write request to the SCCB master.
REQ-013 wr_addr  out  16  register address, stable while wr_req is high.
REQ-014 wr_data  out  8  register data, stable while wr_req is high.
REQ-015 wr_done  in  1  one-cycle pulse from the SCCB master: write finished with ACK.
REQ-016 wr_err  in  1  one-cycle pulse from the SCCB master: write finished with NACK.
REQ-017 busy  out  1  high from the accepted start until DONE or FAIL.
REQ-018 init_done  out  1  high in DONE; stays high until the next start or reset.
REQ-019 init_err  out  1  high in FAIL; stays high until the next start or reset.

Function
REQ-020 States: IDLE, PWRUP, FETCH, LATCH, WRITE, DELAY, NEXT, DONE, FAIL.
REQ-021 IDLE/DONE/FAIL + start -> PWRUP; clear index, retry count, init_done and init_err; set busy.
REQ-022 PWRUP counts PWRUP_CYCLES clks, then -> FETCH.
REQ-023 FETCH drives rom_addr = index, then -> LATCH.
REQ-024 LATCH waits one clk for the ROM latency, captures rom_q into wr_addr/wr_data, then -> WRITE.
REQ-025 WRITE holds wr_req=1 until wr_done or wr_err is sampled; wr_req goes low on the following clk.
REQ-026 The next wr_req rising edge occurs at least one clk after the previous one falls.
REQ-027 wr_done: clear retry count; index==RST_IDX -> DELAY, else -> NEXT.
REQ-028 wr_err with retry count < MAX_RETRY: increment count and re-issue the same entry (-> WRITE via one idle clk).
REQ-029 wr_err with retry count == MAX_RETRY -> FAIL; rom_addr holds the failing index.
REQ-030 wr_done and wr_err high in the same clk are treated as wr_err.
REQ-031 DELAY counts RST_DLY_CYCLES clks, then -> NEXT.
REQ-032 NEXT: index==TABLE_SIZE-1 -> DONE; otherwise increment index -> FETCH.
REQ-033 Delay counters are 32 bits wide; a parameter value of 0 means a one-clk pass-through.
REQ-034 start while busy is ignored.
REQ-035 wr_done or wr_err outside WRITE is ignored.

Reset
REQ-036 Asserting reset in any state forces IDLE immediately.
REQ-037 During reset, all outputs, the index and all counters are 0.
REQ-038 After reset is released, the block stays in IDLE until start.
REQ-039 Reset in the middle of a write drops wr_req asynchronously; no other recovery is performed.

Structure
REQ-040 The state encoding and the 24-bit entry field positions (addr [23:8], data [7:0]) belong in the shared camera package.
REQ-041 The init-table ROM is instantiated externally; no sub-modules are instantiated.
REQ-042 One internal down-counter is shared by PWRUP and DELAY.

Verification
REQ-043 PWRUP_CYCLES=10, RST_DLY_CYCLES=20, TABLE_SIZE=4, with a ROM model and an SCCB model acking after 5 clks -> wr_addr/wr_data sequence 3103/11, 3008/82, 3008/42, 3103/03; init_done=1; busy=0.
REQ-044 Same setup -> exactly 20 clks between wr_done for index 1 and the next wr_req rise; no delay after the other entries.
REQ-045 wr_err on the first two attempts of index 2, then ACK -> 3 requests for 3008/42; sequence completes; init_err=0.
REQ-046 wr_err on 4 attempts of index 3 -> FAIL with init_err=1, init_done=0, rom_addr=3, wr_req=0.
REQ-047 reset asserted while wr_req=1 at index 2 -> all outputs 0 in the same cycle; a new start re-runs from index 0.
REQ-048 start pulsed while busy, and wr_done+wr_err pulsed together -> start has no effect; the simultaneous pulse counts as one retry.

Source files
------------

// File: rtl/ov5640_init_seq_pkg.sv
// Shared camera package: init-sequencer state encoding and init-table entry layout.
// An entry is {reg_addr[15:0], reg_data[7:0]}.
package ov5640_init_seq_pkg;

    localparam int unsigned StateWidth = 4;

    localparam logic [StateWidth-1:0] StIdle  = 4'd0;
    localparam logic [StateWidth-1:0] StPwrup = 4'd1;
    localparam logic [StateWidth-1:0] StFetch = 4'd2;
    localparam logic [StateWidth-1:0] StLatch = 4'd3;
    localparam logic [StateWidth-1:0] StWrite = 4'd4;
    localparam logic [StateWidth-1:0] StDelay = 4'd5;
    localparam logic [StateWidth-1:0] StNext  = 4'd6;
    localparam logic [StateWidth-1:0] StDone  = 4'd7;
    localparam logic [StateWidth-1:0] StFail  = 4'd8;

    localparam int unsigned EntryWidth   = 24;
    localparam int unsigned EntryAddrMsb = 23;
    localparam int unsigned EntryAddrLsb = 8;
    localparam int unsigned EntryDataMsb = 7;
    localparam int unsigned EntryDataLsb = 0;

    function automatic logic [15:0] entry_addr(input logic [EntryWidth-1:0] entry);
        return entry[EntryAddrMsb:EntryAddrLsb];
    endfunction

    function automatic logic [7:0] entry_data(input logic [EntryWidth-1:0] entry);
        return entry[EntryDataMsb:EntryDataLsb];
    endfunction

endpackage

// File: rtl/ov5640_init_seq.sv
// OV5640 init sequencer: walks an external init-table ROM and issues one SCCB
// register write per entry, with power-up wait, post-reset delay and per-entry retries.
module ov5640_init_seq
    import ov5640_init_seq_pkg::*;
#(
    parameter int unsigned TABLE_SIZE     = 250,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned PWRUP_CYCLES   = 1_000_000,
    parameter int unsigned RST_IDX        = 1,
    parameter int unsigned RST_DLY_CYCLES = 250_000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [23:0]           rom_q,
    output logic                  wr_req,
    output logic [15:0]           wr_addr,
    output logic [7:0]            wr_data,
    input  logic                  wr_done,
    input  logic                  wr_err,
    output logic                  busy,
    output logic                  init_done,
    output logic                  init_err
);

    localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(TABLE_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] RstIdx  = ADDR_WIDTH'(RST_IDX);

    logic [StateWidth-1:0] state_q, state_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic [31:0]           retry_q, retry_d;
    logic [31:0]           cnt_q, cnt_d;
    logic [15:0]           waddr_q, waddr_d;
    logic [7:0]            wdata_q, wdata_d;

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        retry_d = retry_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            StIdle, StDone, StFail: begin
                if (start) begin
                    state_d = StPwrup;
                    index_d = '0;
                    retry_d = '0;
                    cnt_d   = PWRUP_CYCLES;
                end
            end
            // Shared down-counter: a load of 0 or 1 both give a single clk in the state.
            StPwrup: begin
                if (cnt_q <= 32'd1) state_d = StFetch;
                else                cnt_d   = cnt_q - 32'd1;
            end
            StFetch: state_d = StLatch;
            StLatch: begin
                waddr_d = entry_addr(rom_q);
                wdata_d = entry_data(rom_q);
                state_d = StWrite;
            end
            // Error wins over a coincident done; a retry re-enters WRITE through LATCH,
            // which gives the idle clk and re-captures the unchanged ROM word.
            StWrite: begin
                if (wr_err) begin
                    if (retry_q < MAX_RETRY) begin
                        retry_d = retry_q + 32'd1;
                        state_d = StLatch;
                    end else begin
                        state_d = StFail;
                    end
                end else if (wr_done) begin
                    retry_d = '0;
                    if (index_q == RstIdx) begin
                        state_d = StDelay;
                        cnt_d   = RST_DLY_CYCLES;
                    end else begin
                        state_d = StNext;
                    end
                end
            end
            StDelay: begin
                if (cnt_q <= 32'd1) state_d = StNext;
                else                cnt_d   = cnt_q - 32'd1;
            end
            StNext: begin
                if (index_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    index_d = index_q + ADDR_WIDTH'(1);
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            index_q <= '0;
            retry_q <= '0;
            cnt_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            retry_q <= retry_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign rom_addr  = index_q;
    assign wr_addr   = waddr_q;
    assign wr_data   = wdata_q;
    assign wr_req    = (state_q == StWrite);
    assign init_done = (state_q == StDone);
    assign init_err  = (state_q == StFail);
    assign busy      = (state_q != StIdle) && (state_q != StDone) && (state_q != StFail);

endmodule
